// File: rtl/pipeline_perf_monitor_if.sv
// pipeline_perf_monitor_if: control, Execute-stage probe and read-port bundle for pipeline_perf_monitor
interface pipeline_perf_monitor_if #(parameter int CNT_W = 32);
    logic             start;
    logic             clear;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             BranchE;
    logic             JumpE;
    logic             PCSrcE;
    logic             rd_req;
    logic [2:0]       rd_addr;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             busy;
    logic             done;
    modport master (
        output start, clear, RegWriteE, MemWriteE, BranchE, JumpE, PCSrcE, rd_req, rd_addr,
        input  rd_valid, rd_data, busy, done
    );
    modport slave (
        input  start, clear, RegWriteE, MemWriteE, BranchE, JumpE, PCSrcE, rd_req, rd_addr,
        output rd_valid, rd_data, busy, done
    );
endinterface

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor: counts cycles, instructions and branch outcomes of a run and
// ends it after IDLE_LIMIT consecutive idle Execute cycles; results via a registered read port.
module pipeline_perf_monitor #(
    parameter int CNT_W      = 32,
    parameter int IDLE_LIMIT = 5
) (
    input logic                    clock,
    input logic                    reset,
    pipeline_perf_monitor_if.slave bus
);
    localparam int IW = $clog2(IDLE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t           state, nxt;
    logic [CNT_W-1:0] cyc_cnt, instr_cnt, br_cnt, br_ok, latency, cyc_nxt, rd_mux;
    logic [IW-1:0]    idle_run;
    logic             ovf, run, active, term, cyc_inc, br_inc, ok_inc, ovf_hit, clr;
    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && v != '1) ? v + 1'b1 : v;
    endfunction
    // Gating with run keeps X on the probe inputs from reaching state outside RUN
    assign run     = state == RUN;
    assign active  = run & (bus.RegWriteE | bus.MemWriteE | bus.BranchE | bus.JumpE);
    assign term    = run & ~active & (int'(idle_run) == IDLE_LIMIT - 1);
    assign cyc_inc = run & ~term;
    assign br_inc  = run & bus.BranchE;
    assign ok_inc  = br_inc & ~bus.PCSrcE;
    assign cyc_nxt = sat(cyc_cnt, cyc_inc);
    assign clr     = bus.clear & ~run;
    assign ovf_hit = (cyc_inc && cyc_cnt == '1) || (active && instr_cnt == '1) ||
                     (br_inc && br_cnt == '1) || (ok_inc && br_ok == '1);
    always_comb begin
        nxt = state == IDLE ? ((bus.start && !bus.clear) ? RUN : IDLE) :
              state == RUN  ? (term ? DONE : RUN) :
                              (bus.clear ? IDLE : DONE);
        rd_mux = bus.rd_addr == 3'd0 ? latency :
                 bus.rd_addr == 3'd1 ? instr_cnt :
                 bus.rd_addr == 3'd2 ? br_cnt :
                 bus.rd_addr == 3'd3 ? br_ok :
                 bus.rd_addr == 3'd4 ? cyc_cnt :
                 bus.rd_addr == 3'd5 ? CNT_W'({ovf, state}) : '0;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            cyc_cnt      <= '0;
            instr_cnt    <= '0;
            br_cnt       <= '0;
            br_ok        <= '0;
            latency      <= '0;
            idle_run     <= '0;
            ovf          <= 1'b0;
        end else begin
            state        <= nxt;
            bus.busy     <= nxt == RUN;
            bus.done     <= nxt == DONE;
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req) bus.rd_data <= rd_mux;
            if (clr) begin
                cyc_cnt   <= '0;
                instr_cnt <= '0;
                br_cnt    <= '0;
                br_ok     <= '0;
                latency   <= '0;
                idle_run  <= '0;
                ovf       <= 1'b0;
            end else begin
                cyc_cnt   <= cyc_nxt;
                instr_cnt <= sat(instr_cnt, active);
                br_cnt    <= sat(br_cnt, br_inc);
                br_ok     <= sat(br_ok, ok_inc);
                if (active) latency <= cyc_nxt;
                idle_run  <= active ? '0 : cyc_inc ? idle_run + 1'b1 : idle_run;
                ovf       <= ovf | ovf_hit;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// tb_pipeline_perf_monitor: table-driven runs, hand-written corner sequences and
// randomized runs checked against a counting model of the monitor.
module tb_pipeline_perf_monitor;
    localparam int LIM = 5;
    localparam longint MAXV = 64'hFFFF_FFFF;
    logic clock = 1'b0;
    logic reset = 1'b0;
    pipeline_perf_monitor_if #(.CNT_W(32)) b ();
    pipeline_perf_monitor_if #(.CNT_W(4))  b4 ();
    pipeline_perf_monitor #(.CNT_W(32), .IDLE_LIMIT(LIM)) dut  (.clock(clock), .reset(reset), .bus(b));
    pipeline_perf_monitor #(.CNT_W(4),  .IDLE_LIMIT(LIM)) dut4 (.clock(clock), .reset(reset), .bus(b4));
    always #5 clock = ~clock;
    int errs = 0;
    int checks = 0;
    longint m_cyc, m_instr, m_br, m_ok, m_lat;
    int m_state, m_idle;
    bit m_ovf;
    logic [63:0] last_rd;
    typedef struct {
        string name;
        logic [15:0] act, br, pc;
        int e_lat, e_instr, e_br, e_ok, e_cyc, e_run;
    } vec_t;
    vec_t tv[5];
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask
    task automatic m_zero();
        m_cyc = 0; m_instr = 0; m_br = 0; m_ok = 0; m_lat = 0; m_idle = 0; m_ovf = 0;
    endtask
    task automatic m_inc(inout longint v);
        if (v == MAXV) m_ovf = 1; else v++;
    endtask
    function automatic logic [63:0] m_val(input logic [2:0] a);
        case (a)
            3'd0: return m_lat;
            3'd1: return m_instr;
            3'd2: return m_br;
            3'd3: return m_ok;
            3'd4: return m_cyc;
            3'd5: return 64'(m_ovf) * 4 + 64'(m_state);
            default: return 0;
        endcase
    endfunction
    // Spec-level model: one call per clock using the inputs presented for that edge
    task automatic m_update();
        if (m_state == 0) begin
            if (b.clear) m_zero();
            else if (b.start) m_state = 1;
        end else if (m_state == 1) begin
            if (b.RegWriteE || b.MemWriteE || b.BranchE || b.JumpE) begin
                m_inc(m_cyc);
                m_inc(m_instr);
                m_idle = 0;
                m_lat = m_cyc;
                if (b.BranchE) begin
                    m_inc(m_br);
                    if (!b.PCSrcE) m_inc(m_ok);
                end
            end else if (m_idle + 1 == LIM) m_state = 2;
            else begin
                m_idle++;
                m_inc(m_cyc);
            end
        end else if (b.clear) begin
            m_zero();
            m_state = 0;
        end
    endtask
    task automatic tick();
        bit pend;
        logic [63:0] exp_rd;
        pend = 0;
        exp_rd = 0;
        if (!reset) begin
            m_zero();
            m_state = 0;
            last_rd = 0;
        end else begin
            pend = b.rd_req;
            if (pend) exp_rd = m_val(b.rd_addr);
            m_update();
        end
        @(posedge clock);
        #1;
        chk("rd_valid", 64'(b.rd_valid), 64'(pend));
        if (pend) last_rd = exp_rd;
        chk(pend ? "rd_data" : "rd_hold", 64'(b.rd_data), last_rd);
        chk("busy", 64'(b.busy), 64'(m_state == 1));
        chk("done", 64'(b.done), 64'(m_state == 2));
    endtask
    task automatic rd(input logic [2:0] a, output logic [63:0] d);
        b.rd_req = 1;
        b.rd_addr = a;
        tick();
        b.rd_req = 0;
        d = 64'(b.rd_data);
    endtask
    task automatic probe_x();
        b.RegWriteE = 'x; b.MemWriteE = 'x; b.BranchE = 'x; b.JumpE = 'x; b.PCSrcE = 'x;
    endtask
    task automatic run_vec(input vec_t v, output int n);
        logic [15:0] a, br, pc;
        a = v.act; br = v.br; pc = v.pc;
        b.start = 1;
        tick();
        b.start = 0;
        n = 0;
        while (n < 100 && b.done !== 1'b1) begin
            b.RegWriteE = a[0] & ~br[0];
            b.MemWriteE = 0;
            b.JumpE = 0;
            b.BranchE = br[0];
            b.PCSrcE = pc[0];
            a = a >> 1; br = br >> 1; pc = pc >> 1;
            tick();
            n++;
        end
        probe_x();
    endtask
    task automatic step4();
        @(posedge clock);
        #1;
    endtask
    task automatic rd4(input logic [2:0] a, output logic [63:0] d);
        b4.rd_req = 1;
        b4.rd_addr = a;
        step4();
        b4.rd_req = 0;
        chk("w4_rd_valid", 64'(b4.rd_valid), 1);
        d = 64'(b4.rd_data);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        logic [63:0] d;
        int n, p;
        bit a;
        logic [3:0] k;
        tv[0] = '{"straight", 16'h03FF, 16'h0000, 16'h0000, 10, 10, 0, 0, 14, 15};
        tv[1] = '{"branches", 16'h000F, 16'h000F, 16'h0005, 4, 4, 4, 2, 8, 9};
        tv[2] = '{"gaps",     16'h0021, 16'h0000, 16'h0000, 6, 2, 0, 0, 10, 11};
        tv[3] = '{"empty",    16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 4, 5};
        tv[4] = '{"mixed",    16'h00B7, 16'h0005, 16'h0004, 8, 6, 2, 1, 12, 13};
        {b.start, b.clear, b.RegWriteE, b.MemWriteE, b.BranchE, b.JumpE, b.PCSrcE, b.rd_req} = '0;
        b.rd_addr = 0;
        {b4.start, b4.clear, b4.RegWriteE, b4.MemWriteE, b4.BranchE, b4.JumpE, b4.PCSrcE, b4.rd_req} = '0;
        b4.rd_addr = 0;
        m_state = 0;
        m_zero();
        last_rd = 0;
        tick();
        reset = 1;
        probe_x();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), d);
            chk("reset_read", d, 0);
        end
        // Reset in the middle of a run
        b.start = 1; tick(); b.start = 0;
        b.RegWriteE = 1; b.MemWriteE = 0; b.BranchE = 0; b.JumpE = 0; b.PCSrcE = 0;
        repeat (3) tick();
        reset = 0; tick(); reset = 1;
        probe_x();
        chk("midrst_busy", 64'(b.busy), 0);
        for (int i = 0; i < 6; i++) begin
            rd(3'(i), d);
            chk("midrst_read", d, 0);
        end
        for (int i = 0; i < 5; i++) begin
            run_vec(tv[i], n);
            chk({tv[i].name, "_run_cycles"}, 64'(n), 64'(tv[i].e_run));
            rd(0, d); chk({tv[i].name, "_latency"}, d, 64'(tv[i].e_lat));
            rd(1, d); chk({tv[i].name, "_instr"}, d, 64'(tv[i].e_instr));
            rd(2, d); chk({tv[i].name, "_br"}, d, 64'(tv[i].e_br));
            rd(3, d); chk({tv[i].name, "_br_ok"}, d, 64'(tv[i].e_ok));
            rd(4, d); chk({tv[i].name, "_cyc"}, d, 64'(tv[i].e_cyc));
            rd(5, d); chk({tv[i].name, "_state"}, d, 2);
            b.clear = 1; tick(); b.clear = 0;
            rd(5, d); chk({tv[i].name, "_cleared"}, d, 0);
        end
        // clear wins over start in IDLE
        b.start = 1; b.clear = 1; tick(); b.start = 0; b.clear = 0;
        chk("clr_start_busy", 64'(b.busy), 0);
        rd(5, d); chk("clr_start_state", d, 0);
        // start ignored in DONE, then back-to-back reads
        run_vec(tv[1], n);
        b.start = 1; tick(); b.start = 0;
        chk("done_holds", 64'(b.done), 1);
        b.rd_req = 1; b.rd_addr = 1; tick();
        chk("b2b_0", 64'(b.rd_data), 4);
        b.rd_addr = 2; tick();
        chk("b2b_1", 64'(b.rd_data), 4);
        b.rd_addr = 7; tick();
        chk("b2b_2", 64'(b.rd_data), 0);
        b.rd_req = 0; tick();
        chk("b2b_end_valid", 64'(b.rd_valid), 0);
        b.clear = 1; tick(); b.clear = 0;
        // Randomized runs with live reads and ignored start/clear during RUN
        for (int r = 0; r < 25; r++) begin
            p = $urandom_range(30, 90);
            b.start = 1; tick(); b.start = 0;
            for (int c = 0; c < 400 && b.done !== 1'b1; c++) begin
                a = c < 150 && $urandom_range(99) < p;
                k = a ? 4'($urandom_range(1, 15)) : 4'd0;
                {b.RegWriteE, b.MemWriteE, b.BranchE, b.JumpE} = k;
                b.PCSrcE = 1'($urandom_range(1));
                b.rd_req = 1'($urandom_range(1));
                b.rd_addr = 3'($urandom_range(7));
                b.start = 1'($urandom_range(1));
                b.clear = $urandom_range(3) == 0;
                tick();
            end
            b.start = 0; b.clear = 0; b.rd_req = 0;
            probe_x();
            chk("rand_run_end", 64'(b.done), 1);
            for (int i = 0; i < 3; i++) begin
                rd(3'($urandom_range(7)), d);
            end
            b.clear = 1; tick(); b.clear = 0;
        end
        // Saturation on a narrow instance
        b4.start = 1; step4(); b4.start = 0;
        b4.RegWriteE = 1;
        repeat (20) step4();
        b4.RegWriteE = 0;
        for (int i = 0; i < 20 && b4.done !== 1'b1; i++) step4();
        chk("w4_done", 64'(b4.done), 1);
        rd4(1, d); chk("w4_instr", d, 15);
        rd4(4, d); chk("w4_cyc", d, 15);
        rd4(0, d); chk("w4_latency", d, 15);
        rd4(5, d); chk("w4_ovf_state", d, 6);
        b4.clear = 1; step4(); b4.clear = 0;
        rd4(5, d); chk("w4_ovf_cleared", d, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
